interrupt_stimulus_driver: RTL and testbench

- Successor to the constant-zero interrupt tie-off used in the core testbenches.
- Drives a WIDTH-bit interrupt vector into the core under test from a queue of timed commands.
- Each command selects a bit mask, a start delay, and pulse or level mode. Level-mode interrupts stay asserted until the bench/model acknowledges them per bit.
- Sits in the testbench between the stimulus sequence (riscv-dv handshake/agent) and the core's external interrupt inputs.

---
 rtl/interrupt_stimulus_driver.sv | 205 ++++++++++++++++++++
 tb/tb_interrupt_stimulus_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_stimulus_driver.sv
// Timed interrupt stimulus driver: queues {mask, mode, delay, hold} commands and drives a registered IRQ vector.
// Optional macro INTR_DRV_JITTER_EN adds LFSR-based 0-7 cycle delay jitter and the jitter_last output.
module interrupt_stimulus_driver #(
  parameter int unsigned ID    = 0,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic             cmd_mode,
  input  logic [CNT_W-1:0] cmd_delay,
  input  logic [CNT_W-1:0] cmd_hold,
  input  logic [WIDTH-1:0] irq_ack,
  input  logic             flush,
  output logic [WIDTH-1:0] interrupts,
  output logic             busy,
  output logic [CNT_W-1:0] fired_count
`ifdef INTR_DRV_JITTER_EN
  ,
  output logic [2:0]       jitter_last
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = WIDTH + 1 + 2 * CNT_W;
  localparam int unsigned SW = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    fifo_mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] irq_q, irq_d;
  logic [CNT_W-1:0] fired_q, fired_d;

  logic             fifo_empty_c, fifo_full_c, push_c, pop_c;
  logic [EW-1:0]    head_c;
  logic [WIDTH-1:0] head_mask_c;
  logic             head_mode_c;
  logic [CNT_W-1:0] head_delay_c, head_hold_c, eff_delay_c;
  logic [WIDTH-1:0] irq_acked_c;
  logic             unused_id;

  assign unused_id = (ID != 32'd0);

  // FIFO status from wrap-bit pointers; flush blocks both push and pop
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready    = !fifo_full_c;
  assign push_c       = cmd_valid && !fifo_full_c && !flush;
  assign pop_c        = (state_q == S_IDLE) && !fifo_empty_c && !flush;
  assign busy         = (state_q != S_IDLE) || !fifo_empty_c;

  assign head_c = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign {head_mask_c, head_mode_c, head_delay_c, head_hold_c} = head_c;
  assign irq_acked_c = irq_q & ~irq_ack;

`ifdef INTR_DRV_JITTER_EN
  logic [15:0]  lfsr_q, lfsr_d;
  logic [2:0]   jitter_last_q, jitter_last_d;
  logic [SW-1:0] delay_sum_c;

  assign lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign delay_sum_c = {1'b0, head_delay_c} + SW'(lfsr_q[2:0]);
  assign eff_delay_c = delay_sum_c[CNT_W] ? {CNT_W{1'b1}} : delay_sum_c[CNT_W-1:0];
  assign jitter_last_d = pop_c ? lfsr_q[2:0] : jitter_last_q;
  assign jitter_last = jitter_last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q        <= 16'hACE1;
      jitter_last_q <= 3'd0;
    end else begin
      lfsr_q        <= lfsr_d;
      jitter_last_q <= jitter_last_d;
    end
  end
`else
  assign eff_delay_c = head_delay_c;
`endif

  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {cmd_mask, cmd_mode, cmd_delay, cmd_hold};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (!fifo_empty_c) state_d = S_DELAY;
        S_DELAY:  if (cnt_q == '0) state_d = S_ACTIVE;
        S_ACTIVE: begin
          if (mode_q) begin
            if (irq_acked_c == '0) state_d = S_IDLE;
          end else if ((cnt_q == '0) || (mask_q == '0)) begin
            state_d = S_IDLE;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: FIFO pointers, counters, latched command, IRQ vector
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    hold_d   = hold_q;
    irq_d    = irq_q;
    fired_d  = fired_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      irq_d    = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      case (state_q)
        S_IDLE: begin
          if (pop_c) begin
            cnt_d  = eff_delay_c;
            mask_d = head_mask_c;
            mode_d = head_mode_c;
            hold_d = head_hold_c;
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) begin
            irq_d   = mask_q;
            cnt_d   = hold_q;
            fired_d = fired_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_ACTIVE: begin
          if (mode_q) begin
            irq_d = irq_acked_c;
          end else if ((cnt_q == '0) || (mask_q == '0)) begin
            irq_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: irq_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      mode_q   <= 1'b0;
      hold_q   <= '0;
      irq_q    <= '0;
      fired_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
      irq_q    <= irq_d;
      fired_q  <= fired_d;
    end
  end

  assign interrupts  = irq_q;
  assign fired_count = fired_q;

endmodule

// File: tb/tb_interrupt_stimulus_driver.sv
// Bench for interrupt_stimulus_driver: timestamp-based command model checked every cycle plus directed literal checks.
// Also exercises a narrow-counter instance for fired_count wrap.
module tb_interrupt_stimulus_driver;

  localparam int DEPTH = 4;
`ifdef INTR_DRV_JITTER_EN
  localparam int JIT = 7;
`else
  localparam int JIT = 0;
`endif

  typedef struct packed {
    logic [3:0]  mask;
    logic        mode;
    logic [15:0] delay;
    logic [15:0] hold;
  } cmd_t;

  logic        clock, reset_n;
  logic        cmd_valid, cmd_ready, cmd_mode, flush, busy;
  logic [3:0]  cmd_mask, irq_ack, interrupts;
  logic [15:0] cmd_delay, cmd_hold, fired_count;
  logic        w_valid, w_ready, w_busy;
  logic [0:0]  w_mask, w_ack, w_irq;
  logic [2:0]  w_delay, w_hold, w_fired;
`ifdef INTR_DRV_JITTER_EN
  logic [2:0]  jitter_last, w_jitter;
`endif

  int checks = 0;
  int errors = 0;

  interrupt_stimulus_driver #(.ID(1), .WIDTH(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_mode(cmd_mode), .cmd_delay(cmd_delay), .cmd_hold(cmd_hold),
    .irq_ack(irq_ack), .flush(flush), .interrupts(interrupts), .busy(busy),
    .fired_count(fired_count)
`ifdef INTR_DRV_JITTER_EN
    , .jitter_last(jitter_last)
`endif
  );

  interrupt_stimulus_driver #(.ID(2), .WIDTH(1), .DEPTH(2), .CNT_W(3)) dut_w (
    .clock(clock), .reset_n(reset_n), .cmd_valid(w_valid), .cmd_ready(w_ready),
    .cmd_mask(w_mask), .cmd_mode(1'b0), .cmd_delay(w_delay), .cmd_hold(w_hold),
    .irq_ack(w_ack), .flush(1'b0), .interrupts(w_irq), .busy(w_busy),
    .fired_count(w_fired)
`ifdef INTR_DRV_JITTER_EN
    , .jitter_last(w_jitter)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Model: commands carry absolute assertion timestamps rather than countdowns
  cmd_t        mq[$];
  cmd_t        cur;
  bit          have_cur;
  int          n_edge = 0;
  int          assert_edge;
  logic [3:0]  lvl, m_irq;
  logic [15:0] m_fired, m_lfsr;
  logic [2:0]  m_jit;

  task automatic model_step();
    bit   push;
    int   eff;
    cmd_t c;
    if (!reset_n) begin
      mq.delete();
      have_cur = 0;
      m_irq    = '0;
      m_fired  = '0;
      m_jit    = '0;
      m_lfsr   = 16'hACE1;
      return;
    end
    push = cmd_valid && (mq.size() < DEPTH) && !flush;
    if (flush) begin
      mq.delete();
      have_cur = 0;
      m_irq    = '0;
    end else if (have_cur) begin
      if (n_edge == assert_edge) begin
        m_irq = cur.mask;
        lvl   = cur.mask;
        m_fired++;
      end else if (n_edge > assert_edge) begin
        if (cur.mode) begin
          lvl   = lvl & ~irq_ack;
          m_irq = lvl;
          if (lvl == 4'd0) have_cur = 0;
        end else if (cur.mask == 4'd0 || n_edge == assert_edge + int'(cur.hold) + 1) begin
          m_irq    = '0;
          have_cur = 0;
        end
      end
    end else if (mq.size() != 0) begin
      cur = mq.pop_front();
      eff = int'(cur.delay);
`ifdef INTR_DRV_JITTER_EN
      eff   = eff + int'(m_lfsr[2:0]);
      if (eff > 65535) eff = 65535;
      m_jit = m_lfsr[2:0];
`endif
      assert_edge = n_edge + 1 + eff;
      have_cur    = 1;
    end
    if (push) begin
      c.mask  = cmd_mask;
      c.mode  = cmd_mode;
      c.delay = cmd_delay;
      c.hold  = cmd_hold;
      mq.push_back(c);
    end
`ifdef INTR_DRV_JITTER_EN
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    n_edge++;
  endtask

  // Compare the main instance against the model after every rising edge
  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      check("m_interrupts", 32'(interrupts), 32'(m_irq));
      check("m_fired_count", 32'(fired_count), 32'(m_fired));
      check("m_cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      check("m_busy", 32'(busy), 32'(have_cur || mq.size() != 0));
`ifdef INTR_DRV_JITTER_EN
      check("m_jitter_last", 32'(jitter_last), 32'(m_jit));
`endif
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic push_cmd(input logic [3:0] m, input logic md, input logic [15:0] d, input logic [15:0] h);
    bit rdy;
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_mask  = m;
    cmd_mode  = md;
    cmd_delay = d;
    cmd_hold  = h;
    for (int k = 0; k < 200 && !done; k++) begin
      rdy = cmd_ready;
      @(negedge clock);
      if (rdy) done = 1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed %0b, wanted 1", cmd_ready);
    end
  endtask

  task automatic wait_irq(input logic [3:0] exp, input int bound, output int lat);
    lat = -1;
    for (int k = 0; k <= bound; k++) begin
      if (interrupts == exp) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_irq: interrupts %0h, wanted %0h", interrupts, exp);
    end
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int k = 0; k <= bound && !ok; k++) begin
      if (!busy) ok = 1;
      else @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy %0b, wanted 0", busy);
    end
  endtask

  initial begin
    int lat;
    int acc;
    bit rdy;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_mask = '0; cmd_mode = 1'b0; cmd_delay = '0; cmd_hold = '0;
    irq_ack = '0; flush = 1'b0;
    w_valid = 1'b0; w_mask = '0; w_ack = '0; w_delay = '0; w_hold = '0;
    #2;
    check("rst_interrupts", 32'(interrupts), 32'h0);
    check("rst_fired", 32'(fired_count), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Pulse basic: delay 3, hold 2
    push_cmd(4'b0101, 1'b0, 16'd3, 16'd2);
    wait_irq(4'b0101, 40, lat);
    check_range("pulse_latency", lat, 5, 5 + JIT);
    check("pulse_fired", 32'(fired_count), 32'd1);
    tick(2);
    check("pulse_last_high", 32'(interrupts), 32'h5);
    tick(1);
    check("pulse_cleared", 32'(interrupts), 32'h0);
    wait_idle(5);

    // Level with per-bit acks
    push_cmd(4'b1100, 1'b1, 16'd0, 16'd0);
    wait_irq(4'b1100, 40, lat);
    check_range("level_latency", lat, 2, 2 + JIT);
    irq_ack = 4'b1000;
    tick(1);
    check("level_ack3", 32'(interrupts), 32'h4);
    irq_ack = 4'b0100;
    tick(1);
    check("level_ack2", 32'(interrupts), 32'h0);
    check("level_busy_low", 32'(busy), 32'h0);
    irq_ack = 4'b0000;
    check("level_fired", 32'(fired_count), 32'd2);

    // Ack held through entry is ignored on the entering edge; extra ack bits harmless
    irq_ack = 4'b1111;
    push_cmd(4'b0011, 1'b1, 16'd0, 16'd0);
    wait_irq(4'b0011, 40, lat);
    check_range("entry_ack_latency", lat, 2, 2 + JIT);
    tick(1);
    check("entry_ack_cleared", 32'(interrupts), 32'h0);
    irq_ack = 4'b0000;
    wait_idle(5);

    // FIFO back-pressure: six pulse commands, delay 10
    push_cmd(4'b0001, 1'b0, 16'd10, 16'd1);
    push_cmd(4'b0010, 1'b0, 16'd10, 16'd1);
    push_cmd(4'b0100, 1'b0, 16'd10, 16'd1);
    push_cmd(4'b1000, 1'b0, 16'd10, 16'd1);
    push_cmd(4'b1001, 1'b0, 16'd10, 16'd1);
    check("fifo_full_ready", 32'(cmd_ready), 32'h0);
    check("fifo_full_busy", 32'(busy), 32'h1);
    push_cmd(4'b0110, 1'b0, 16'd10, 16'd1);
    wait_idle(300);
    check("fifo_fired", 32'(fired_count), 32'd9);

    // Zero mask level then single-cycle pulse
    push_cmd(4'b0000, 1'b1, 16'd0, 16'd0);
    push_cmd(4'b0001, 1'b0, 16'd0, 16'd0);
    wait_irq(4'b0001, 40, lat);
    check_range("zero_mask_latency", lat, 4, 4 + 2 * JIT);
    check("zero_mask_fired", 32'(fired_count), 32'd11);
    tick(1);
    check("zero_hold_cleared", 32'(interrupts), 32'h0);
    wait_idle(5);

    // Flush mid-ACTIVE with two queued and one dropped offer
    push_cmd(4'b1111, 1'b1, 16'd0, 16'd0);
    push_cmd(4'b0001, 1'b0, 16'd5, 16'd0);
    push_cmd(4'b0010, 1'b0, 16'd5, 16'd0);
    wait_irq(4'b1111, 40, lat);
    check("flush_pre_busy", 32'(busy), 32'h1);
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_mask = 4'b0100;
    tick(1);
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("flush_interrupts", 32'(interrupts), 32'h0);
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_ready", 32'(cmd_ready), 32'h1);
    check("flush_fired", 32'(fired_count), 32'd12);
    tick(3);
    check("flush_drop_busy", 32'(busy), 32'h0);

    // Async reset during a long delay, then normal operation
    push_cmd(4'b0001, 1'b0, 16'd20, 16'd0);
    tick(5);
    check("arst_pre_fired", 32'(fired_count), 32'd12);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_fired", 32'(fired_count), 32'h0);
    check("arst_interrupts", 32'(interrupts), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ready", 32'(cmd_ready), 32'h1);
    tick(3);
    reset_n = 1'b1;
    tick(1);
    push_cmd(4'b0010, 1'b0, 16'd2, 16'd1);
    wait_irq(4'b0010, 40, lat);
    check_range("arst_resume_latency", lat, 4, 4 + JIT);
    tick(1);
    check("arst_resume_hold", 32'(interrupts), 32'h2);
    tick(1);
    check("arst_resume_clear", 32'(interrupts), 32'h0);
    check("arst_resume_fired", 32'(fired_count), 32'd1);

    // fired_count wrap on a 3-bit counter instance: nine commands -> 1
    acc = 0;
    w_valid = 1'b1;
    for (int k = 0; k < 400 && acc < 9; k++) begin
      rdy = w_ready;
      @(negedge clock);
      if (rdy) acc++;
      if (acc == 9) w_valid = 1'b0;
    end
    w_valid = 1'b0;
    check("wrap_accepted", 32'(acc), 32'd9);
    for (int k = 0; k < 300 && w_busy; k++) @(negedge clock);
    check("wrap_idle", 32'(w_busy), 32'h0);
    check("wrap_fired", 32'(w_fired), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
